// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative multiply/divide unit for a multicycle RV64 datapath.
//            MUL/MULH use radix-2 shift-add and DIV/REM use restoring division,
//            both on operand magnitudes with a sign fix-up on the last cycle.
// Ports    : clk    - clock, rising edge
//            Reset  - asynchronous active-high reset
//            start  - operation request, sampled only when idle
//            op     - 00 MUL, 01 MULH, 10 DIV, 11 REM
//            a, b   - rs1 / rs2 operands (two's complement)
//            busy   - high while calculating or presenting the result
//            done   - one-cycle completion strobe
//            result - registered result, held until the next accepted start
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            Reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int              C_CNT_W    = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] C_MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [1:0]      C_OP_MUL   = 2'b00;
   localparam logic [1:0]      C_OP_MULH  = 2'b01;
   localparam logic [1:0]      C_OP_DIV   = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [1:0]          r_op;
   logic                r_sa;
   logic                r_sb;
   logic [XLEN-1:0]     r_mag_a;
   logic [XLEN-1:0]     r_mag_b;
   logic [C_CNT_W-1:0]  r_cnt;
   // Multiply: {partial product high, multiplier shifting out at bit 0}.
   // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
   logic [2*XLEN-1:0]   r_prod;

   logic [XLEN-1:0]     w_mag_a;
   logic [XLEN-1:0]     w_mag_b;
   logic                w_special;
   logic [XLEN-1:0]     w_special_res;
   logic [XLEN:0]       w_mul_sum;
   logic [2*XLEN-1:0]   w_mul_next;
   logic [XLEN:0]       w_div_shift;
   logic [XLEN:0]       w_div_diff;
   logic [2*XLEN-1:0]   w_div_next;
   logic [2*XLEN-1:0]   w_prod_next;
   logic [2*XLEN-1:0]   w_prod_neg;
   logic [XLEN-1:0]     w_rem_neg;
   logic [XLEN-1:0]     w_fixed;
   logic                w_last;

   // Negating the most-negative value wraps back to itself, which read as
   // unsigned is exactly its magnitude 2^(XLEN-1).
   assign w_mag_a = a[XLEN-1] ? -a : a;
   assign w_mag_b = b[XLEN-1] ? -b : b;

   // Divide-by-zero and signed overflow complete without iterating.
   always_comb begin
      w_special     = 1'b0;
      w_special_res = '0;
      if (op[1]) begin
         if (b == '0) begin
            w_special     = 1'b1;
            w_special_res = (op == C_OP_DIV) ? '1 : a;
         end else if ((a == C_MOST_NEG) && (b == '1)) begin
            w_special     = 1'b1;
            w_special_res = (op == C_OP_DIV) ? a : '0;
         end
      end
   end

   // Shift-add step: the add needs one carry bit, which becomes the new MSB
   // after the right shift.
   assign w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} +
                       (r_prod[0] ? {1'b0, r_mag_a} : {(XLEN+1){1'b0}});
   assign w_mul_next = {w_mul_sum, r_prod[XLEN-1:1]};

   // Restoring step: the shifted remainder can exceed XLEN bits, so the trial
   // subtract is XLEN+1 wide and its MSB is the borrow.
   assign w_div_shift = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
   assign w_div_diff  = w_div_shift - {1'b0, r_mag_b};
   assign w_div_next  = w_div_diff[XLEN]
                      ? {w_div_shift[XLEN-1:0], r_prod[XLEN-2:0], 1'b0}
                      : {w_div_diff[XLEN-1:0],  r_prod[XLEN-2:0], 1'b1};

   assign w_prod_next = r_op[1] ? w_div_next : w_mul_next;
   // Low half of the full-width negation is also the negated quotient.
   assign w_prod_neg  = -w_prod_next;
   assign w_rem_neg   = -w_prod_next[2*XLEN-1:XLEN];
   assign w_last      = (r_cnt == C_CNT_W'(1));

   always_comb begin
      case (r_op)
         C_OP_MUL:  w_fixed = (r_sa ^ r_sb) ? w_prod_neg[XLEN-1:0]  : w_prod_next[XLEN-1:0];
         C_OP_MULH: w_fixed = (r_sa ^ r_sb) ? w_prod_neg[2*XLEN-1:XLEN]
                                            : w_prod_next[2*XLEN-1:XLEN];
         C_OP_DIV:  w_fixed = (r_sa ^ r_sb) ? w_prod_neg[XLEN-1:0]  : w_prod_next[XLEN-1:0];
         default:   w_fixed = r_sa ? w_rem_neg : w_prod_next[2*XLEN-1:XLEN];
      endcase
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_next_state = w_special ? S_DONE : S_CALC;
         end
         S_CALC: begin
            busy = 1'b1;
            if (w_last) w_next_state = S_DONE;
         end
         S_DONE: begin
            busy         = 1'b1;
            done         = 1'b1;
            w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_op    <= '0;
         r_sa    <= 1'b0;
         r_sb    <= 1'b0;
         r_mag_a <= '0;
         r_mag_b <= '0;
         r_cnt   <= '0;
         r_prod  <= '0;
         result  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op    <= op;
                  r_sa    <= a[XLEN-1];
                  r_sb    <= b[XLEN-1];
                  r_mag_a <= w_mag_a;
                  r_mag_b <= w_mag_b;
                  r_cnt   <= C_CNT_W'(XLEN);
                  r_prod  <= {{XLEN{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
                  if (w_special) result <= w_special_res;
               end
            end
            S_CALC: begin
               r_prod <= w_prod_next;
               r_cnt  <= r_cnt - C_CNT_W'(1);
               if (w_last) result <= w_fixed;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit (XLEN=64) using an expected
//            result queue filled at issue time and drained on done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

   localparam logic [63:0] C_MIN = 64'h8000_0000_0000_0000;

   logic        clk = 1'b0;
   logic        Reset;
   logic        start;
   logic [1:0]  op;
   logic [63:0] a;
   logic [63:0] b;
   logic        busy;
   logic        done;
   logic [63:0] result;

   typedef struct {
      logic [63:0] exp;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   muldiv_unit #(.XLEN(64)) dut (
      .clk    (clk),
      .Reset  (Reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
      logic [127:0]       p;
      logic signed [63:0] xs;
      logic signed [63:0] ys;
      xs = x;
      ys = y;
      p  = {{64{x[63]}}, x} * {{64{y[63]}}, y};
      case (o)
         2'b00:   return p[63:0];
         2'b01:   return p[127:64];
         2'b10: begin
            if (y == 64'd0) return '1;
            if (x == C_MIN && y == '1) return x;
            return xs / ys;
         end
         default: begin
            if (y == 64'd0) return x;
            if (x == C_MIN && y == '1) return 64'd0;
            return xs % ys;
         end
      endcase
   endfunction

   // Called at the negedge right after the acceptance edge.
   task automatic wait_done(input string tag, input bit disturb);
      int          lat;
      exp_t        e;
      logic [63:0] held;
      lat = 0;
      while (!done && lat < 200) begin
         if (disturb && lat == 10) begin
            start = 1'b1;
            a     = ~a;
            b     = b + 64'd1;
            op    = ~op;
         end
         if (disturb && lat == 11) start = 1'b0;
         @(negedge clk);
         lat++;
      end
      check({tag, "/done"}, {63'b0, done}, 64'd1);
      e = sb_q.pop_front();
      check({tag, "/res"}, result, e.exp);
      check({tag, "/lat"}, 64'(lat), 64'(e.lat));
      held = result;
      @(negedge clk);
      check({tag, "/done1cyc"}, {63'b0, done}, 64'd0);
      check({tag, "/idle"}, {63'b0, busy}, 64'd0);
      check({tag, "/held"}, result, held);
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [63:0] x,
                         input logic [63:0] y, input logic [63:0] exp, input int lat,
                         input bit disturb);
      exp_t e;
      for (int i = 0; i < 200 && busy; i++) @(negedge clk);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      e.exp = exp;
      e.lat = lat;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      a     = {$urandom, $urandom};
      b     = {$urandom, $urandom};
      check({tag, "/busy"}, {63'b0, busy}, 64'd1);
      wait_done(tag, disturb);
   endtask

   initial begin
      exp_t        e;
      logic [1:0]  ro;
      logic [63:0] rx;
      logic [63:0] ry;
      int          seen;
      bit          spec;

      Reset = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      check("rst/result", result, 64'd0);
      check("rst/busy", {63'b0, busy}, 64'd0);
      check("rst/done", {63'b0, done}, 64'd0);
      Reset = 1'b0;
      @(negedge clk);

      // Directed vectors; the first one also pulses start and alters a mid-CALC.
      run_op("mul_7_m3",    2'b00, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 64, 1'b1);
      run_op("mulh_min_2",  2'b01, C_MIN, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0);
      run_op("mulh_m1_m1",  2'b01, '1, '1, 64'd0, 64, 1'b0);
      run_op("div_m7_2",    2'b10, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64, 1'b0);
      run_op("rem_m7_2",    2'b11, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0);
      run_op("rem_7_m2",    2'b11, 64'd7, -64'sd2, 64'd1, 64, 1'b0);
      run_op("div_5_0",     2'b10, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
      run_op("rem_5_0",     2'b11, 64'd5, 64'd0, 64'd5, 0, 1'b0);
      run_op("div_min_m1",  2'b10, C_MIN, '1, C_MIN, 0, 1'b0);
      run_op("rem_min_m1",  2'b11, C_MIN, '1, 64'd0, 0, 1'b0);
      run_op("div_min_3",   2'b10, C_MIN, 64'd3, 64'hD555_5555_5555_5556, 64, 1'b0);

      // Back-to-back: start held high through DONE.
      op    = 2'b00;
      a     = 64'd9;
      b     = 64'd11;
      start = 1'b1;
      e.exp = 64'd99;
      e.lat = 64;
      sb_q.push_back(e);
      @(negedge clk);
      op    = 2'b10;
      a     = -64'sd100;
      b     = 64'd7;
      wait_done("b2b_first", 1'b0);
      e.exp = -64'sd14;
      e.lat = 64;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      check("b2b/accept", {63'b0, busy}, 64'd1);
      wait_done("b2b_second", 1'b0);

      // Asynchronous reset in the middle of an operation.
      op    = 2'b00;
      a     = 64'd5;
      b     = 64'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      #2 Reset = 1'b1;
      #1;
      check("arst/busy", {63'b0, busy}, 64'd0);
      check("arst/done", {63'b0, done}, 64'd0);
      check("arst/result", result, 64'd0);
      @(negedge clk);
      Reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      check("arst/no_done", 64'(seen), 64'd0);

      // Random vectors against the arithmetic model.
      for (int i = 0; i < 10; i++) begin
         ro = 2'($urandom_range(0, 3));
         rx = {$urandom, $urandom};
         case (i % 4)
            0:       ry = {$urandom, $urandom};
            1:       ry = 64'($urandom_range(1, 1000));
            2:       ry = -64'($urandom_range(1, 1000));
            default: ry = (i == 3) ? 64'd0 : {32'd0, $urandom};
         endcase
         spec = ro[1] && (ry == 64'd0 || (rx == C_MIN && ry == '1));
         run_op($sformatf("rnd%0d_op%0d", i, ro), ro, rx, ry, model(ro, rx, ry), spec ? 0 : 64, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the multicycle RV64 datapath. The control unit drives it with a start pulse and stalls in a wait state until `done`. Operands come from the A and B operand registers, and the result is written back through the register-file write mux. Multiplication uses radix-2 shift-add and division uses restoring division, both on operand magnitudes with a sign fix-up at the end.

## Interface
Parameters:
- `XLEN`, default 64: operand and result width.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request an operation; sampled only in IDLE.
- `op`, in, 2: operation select.
  - 00 MUL: low XLEN bits of the product.
  - 01 MULH: high XLEN bits of the signed×signed product.
  - 10 DIV: signed quotient.
  - 11 REM: signed remainder.
- `a`, in, XLEN: rs1 operand (dividend or multiplicand); two's complement.
- `b`, in, XLEN: rs2 operand (divisor or multiplier); two's complement.
- `busy`, out, 1: high in CALC and DONE.
- `done`, out, 1: high for exactly one cycle, in DONE.
- `result`, out, XLEN: registered result; valid while `done`=1; holds its value until the next accepted start.

## Operation
States:
- **IDLE:** wait for `start`.
- **CALC:** one iteration per cycle.
- **DONE:** result presented.

Acceptance (IDLE, `start`=1 at edge k):
- Latch `op`, `sa`=a[XLEN-1] and `sb`=b[XLEN-1].
- Latch |a| and |b| as unsigned XLEN-bit magnitudes; the magnitude of the most-negative value is 2^(XLEN-1).
- Load the iteration counter with XLEN and go to CALC.
- Special cases bypass CALC and go straight to DONE with the result registered at edge k:
  - DIV, b=0: result = all ones.
  - REM, b=0: result = a.
  - DIV, a=most-negative and b=-1: result = a.
  - REM, a=most-negative and b=-1: result = 0.
- `start` in CALC or DONE is ignored; there is no queueing.

CALC:
- MUL and MULH use a 2·XLEN-bit product register. Each cycle, add the multiplicand when the current multiplier bit is 1, then shift.
- DIV and REM use restoring division. Each cycle, shift the partial remainder left one bit and bring in the next dividend bit. Trial-subtract the divisor magnitude; if the result is non-negative, keep it and set the quotient bit to 1, otherwise restore and set the quotient bit to 0.
- Decrement the counter each cycle. On the cycle the counter goes 1→0, apply the sign fix-up, register `result` and go to DONE.

Sign fix-up:
- MUL and MULH: negate the 2·XLEN-bit product when sa^sb. MUL outputs the low half, MULH the high half.
- DIV: negate the quotient when sa^sb.
- REM: negate the remainder when sa.

DONE:
- `done`=1 for one cycle, then IDLE unconditionally.

Reset (asynchronous, any state, including mid-operation):
- state=IDLE, counter=0, internal registers=0.
- `result`=0, `busy`=0, `done`=0.
- The aborted operation produces no `done`.

## Timing
- Normal latency: accepted at edge k, DONE entered at edge k+XLEN. `done` is visible in the cycle after edge k+XLEN (65 clocks for XLEN=64).
- Special-case latency: DONE entered at edge k, so `done` is visible in the cycle after edge k.
- `busy` rises in the cycle after edge k and falls after the DONE cycle.
- Back-to-back: the earliest next start is sampled at the edge that leaves DONE. That edge returns the block to IDLE and does not accept, so the start is accepted one cycle after DONE.
- `a`, `b` and `op` must be stable only at the acceptance edge; later changes have no effect.
- `result` is registered, with no combinational path from the inputs.

## Test plan
- MUL a=7, b=-3 → `result`=0xFFFF_FFFF_FFFF_FFEB; `done` exactly 64 edges after acceptance, high for 1 cycle.
- MULH a=0x8000_0000_0000_0000, b=2 → `result`=0xFFFF_FFFF_FFFF_FFFF. MULH a=b=0xFFFF_FFFF_FFFF_FFFF → 0.
- DIV a=-7, b=2 → 0xFFFF_FFFF_FFFF_FFFD. REM a=-7, b=2 → 0xFFFF_FFFF_FFFF_FFFF. REM a=7, b=-2 → 1.
- DIV 5/0 → all ones, `done` in the cycle after acceptance. REM 5/0 → 5. DIV min/-1 → 0x8000_0000_0000_0000. REM min/-1 → 0.
- `start` pulsed and `a` changed during CALC → ignored; result unaffected. A start held high through DONE → the next operation is accepted the cycle after DONE.
- `Reset` asserted at iteration 30 → `busy`, `done` and `result` are 0 immediately (asynchronous). After release, no `done` appears until a new start.
